mdu_acc: RTL and testbench
==========================

Name: mdu_acc

Overview:
- Parametrised, multi-cycle integer multiply/divide unit with architectural HI/LO accumulator registers.
- Successor to the single-cycle ALU's MUL/MADD/MADDU path: HI/LO become real state, multiply/divide become iterative, and MSUB and DIV/DIVU are added.
- Sits beside the ALU in EX and is driven by the decoder through a valid/ready handshake; the pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- BITS_PER_CYC, 1, partial-product/quotient bits retired per CALC cycle; legal values 1, 2, 4, must divide WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- op  in  3  000 MULT, 001 MULTU, 010 MADD, 011 MADDU, 100 MSUB, 101 DIV, 110 DIVU, 111 MTHILO.
- a  in  WIDTH  operand 1 / dividend / new HI value.
- b  in  WIDTH  operand 2 / divisor / new LO value.
- flush  in  1  synchronous abort of the in-flight op.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- hi  out  WIDTH  architectural HI register.
- lo  out  WIDTH  architectural LO register.
- dbz  out  1  last DIV/DIVU had divisor 0; valid while out_valid.

Behaviour:
- Reset: asynchronous on rst_n low.
  - state=IDLE; hi=0; lo=0; dbz=0; out_valid=0; in_ready=1.
  - Assertion mid-operation discards the op immediately.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 captures op, a and b.
  - MTHILO goes directly to DONE with hi<=a, lo<=b.
  - Every other op goes to CALC with counter=WIDTH/BITS_PER_CYC.
- Operand prep on accept:
  - Signed ops (MULT, MADD, MSUB, DIV) use |a| and |b|.
  - sign_p = a[W-1]^b[W-1]; sign_r = a[W-1].
- CALC:
  - Multiply: unsigned shift-add on a 2*WIDTH product register.
  - Divide: restoring shift-subtract.
  - BITS_PER_CYC bits per cycle; counter decrements; at counter==1 go to FIX.
- FIX (1 cycle):
  - Apply signs: product negated if sign_p; quotient negated if sign_p; remainder negated if sign_r.
  - Write HI/LO:
    - MULT/MULTU: {hi,lo} <= P.
    - MADD/MADDU: {hi,lo} <= {hi,lo}+P, modulo 2^(2W).
    - MSUB: {hi,lo} <= {hi,lo}-P.
    - DIV/DIVU: lo <= quotient, hi <= remainder.
  - Go to DONE.
- DONE:
  - out_valid=1; in_ready=0.
  - hi, lo and dbz are held stable until out_valid && out_ready, then return to IDLE.
  - No same-cycle accept of a new op.
- Latency, accept to out_valid:
  - WIDTH/BITS_PER_CYC+2 cycles (34 at defaults).
  - MTHILO: 1 cycle.
- Divide special cases, detected at accept:
  - b==0: skip CALC, go to FIX; lo<=all ones; hi<=a; dbz=1.
  - DIV with a==MIN and b==-1: lo<=MIN, hi<=0, no trap.
  - dbz is cleared on any other accepted op.
- flush:
  - In CALC or FIX: returns to IDLE next cycle. HI/LO are untouched; a write scheduled in that same FIX cycle is suppressed. out_valid is never raised.
  - In DONE: ignored, since HI/LO are already committed.
  - In IDLE: any simultaneous in_valid is dropped.
- hi/lo change only in FIX, on MTHILO accept, or on reset.

Optional Feature:
- Macro MDU_DIV_EN.
- Defined: DIV/DIVU behave as above.
- Undefined:
  - No divider datapath is built.
  - DIV/DIVU complete in 1 cycle (IDLE→DONE) with hi and lo unchanged and dbz=1 as an unimplemented-op flag.
  - Multiply timing is unchanged.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, reset HI/LO → out_valid exactly 34 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MTHILO a=0, b=0xFFFFFFFF, then MADDU a=1, b=1 → hi=0x00000001, lo=0x00000000; then MSUB a=1, b=1 → hi=0, lo=0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, dbz=0. DIVU same operands → lo=0x7FFFFFFC, hi=1.
- DIV a=0x1234, b=0 → out_valid after 2 cycles; lo=0xFFFFFFFF, hi=0x1234, dbz=1. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, in_ready stays 0, hi/lo stable; accepted on the 6th cycle, then in_ready=1.
- Abort paths:
  - flush in CALC cycle 10 → IDLE next cycle, hi/lo keep prior values, no out_valid.
  - rst_n pulsed low mid-CALC → hi=lo=0, out_valid=0, in_ready=1 asynchronously.

Source files
------------

// File: rtl/mdu_acc.sv
// Iterative multiply/divide unit with architectural HI/LO accumulator registers.
// Define MDU_DIV_EN to build the restoring divider. Without it, DIV/DIVU retire at once and raise dbz.
module mdu_acc #(
   parameter int WIDTH        = 32,
   parameter int BITS_PER_CYC = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dbz
);

   localparam int STEPS = WIDTH / BITS_PER_CYC;
   localparam int CNT_W = $clog2(STEPS + 1);

   localparam logic [2:0] OP_MULT   = 3'b000;
   localparam logic [2:0] OP_MULTU  = 3'b001;
   localparam logic [2:0] OP_MADD   = 3'b010;
   localparam logic [2:0] OP_MADDU  = 3'b011;
   localparam logic [2:0] OP_MSUB   = 3'b100;
   localparam logic [2:0] OP_DIV    = 3'b101;
   localparam logic [2:0] OP_DIVU   = 3'b110;
   localparam logic [2:0] OP_MTHILO = 3'b111;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt_p1;
   logic [2:0]           op_p0;
   logic [WIDTH-1:0]     mcand_p0;
   logic                 sign_p_p0;
   logic [2*WIDTH-1:0]   acc_p1;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [2*WIDTH-1:0]   hilo_fix;
   logic                 accept;
   logic                 in_is_div;
   logic                 in_is_signed;

   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   // Shift-add: multiplier sits in the low half and is consumed LSB first.
   function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0]   m);
      logic [WIDTH:0]     s;
      logic [2*WIDTH-1:0] r;
      r = acc;
      for (int i = 0; i < BITS_PER_CYC; i++) begin
         s = {1'b0, r[2*WIDTH-1:WIDTH]} + (r[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
         r = {s, r[WIDTH-1:1]};
      end
      return r;
   endfunction

`ifdef MDU_DIV_EN
   logic [WIDTH-1:0] a_p0;
   logic             sign_r_p0;
   logic             dz_p0;
   logic             in_dz;
   logic             op_is_div;

   // Restoring division: remainder in the high half, dividend/quotient in the low half.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0]   d);
      logic [WIDTH:0]     rem;
      logic [WIDTH-1:0]   q;
      logic [2*WIDTH-1:0] r;
      r = acc;
      for (int i = 0; i < BITS_PER_CYC; i++) begin
         rem = {r[2*WIDTH-1:WIDTH], r[WIDTH-1]};
         q   = {r[WIDTH-2:0], 1'b0};
         if (rem >= {1'b0, d}) begin
            rem  = rem - {1'b0, d};
            q[0] = 1'b1;
         end
         r = {rem[WIDTH-1:0], q};
      end
      return r;
   endfunction

   assign in_dz     = (b == '0);
   assign op_is_div = (op_p0 == OP_DIV) || (op_p0 == OP_DIVU);
`endif

   assign accept       = (state == IDLE) && in_valid && !flush;
   assign in_is_div    = (op == OP_DIV) || (op == OP_DIVU);
   assign in_is_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid && !flush) begin
               if (op == OP_MTHILO) state_nxt = DONE;
`ifdef MDU_DIV_EN
               else if (in_is_div)  state_nxt = (b == '0) ? FIX : CALC;
`else
               else if (in_is_div)  state_nxt = DONE;
`endif
               else                 state_nxt = CALC;
            end
         end
         CALC: begin
            if (flush)                      state_nxt = IDLE;
            else if (cnt_p1 == CNT_W'(1))   state_nxt = FIX;
         end
         FIX:  state_nxt = flush ? IDLE : DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0: operand capture on accept; stage p1: iterative accumulator.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p0     <= op;
         sign_p_p0 <= in_is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MDU_DIV_EN
         a_p0      <= a;
         sign_r_p0 <= (op == OP_DIV) & a[WIDTH-1];
         dz_p0     <= in_dz;
         if (in_is_div) begin
            mcand_p0 <= in_is_signed ? mag(b) : b;
            acc_p1   <= {{WIDTH{1'b0}}, (in_is_signed ? mag(a) : a)};
         end else
`endif
         begin
            mcand_p0 <= in_is_signed ? mag(a) : a;
            acc_p1   <= {{WIDTH{1'b0}}, (in_is_signed ? mag(b) : b)};
         end
      end else if (state == CALC) begin
`ifdef MDU_DIV_EN
         if (op_is_div) acc_p1 <= div_step(acc_p1, mcand_p0);
         else
`endif
         acc_p1 <= mul_step(acc_p1, mcand_p0);
      end
   end

   // Stage p2: sign fix-up and HI/LO update value.
   always_comb begin
      prod_fix = sign_p_p0 ? -acc_p1 : acc_p1;
      hilo_fix = {hi, lo};
      case (op_p0)
         OP_MULT, OP_MULTU: hilo_fix = prod_fix;
         OP_MADD, OP_MADDU: hilo_fix = {hi, lo} + prod_fix;
         OP_MSUB:           hilo_fix = {hi, lo} - prod_fix;
`ifdef MDU_DIV_EN
         OP_DIV, OP_DIVU: begin
            if (dz_p0) hilo_fix = {a_p0, {WIDTH{1'b1}}};
            else       hilo_fix = {(sign_r_p0 ? -acc_p1[2*WIDTH-1:WIDTH] : acc_p1[2*WIDTH-1:WIDTH]),
                                   (sign_p_p0 ? -acc_p1[WIDTH-1:0]       : acc_p1[WIDTH-1:0])};
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p1 <= '0;
         hi     <= '0;
         lo     <= '0;
         dbz    <= 1'b0;
      end else begin
         if (accept) begin
            cnt_p1 <= CNT_W'(STEPS);
`ifdef MDU_DIV_EN
            dbz    <= in_is_div & in_dz;
`else
            dbz    <= in_is_div;
`endif
            if (op == OP_MTHILO) begin
               hi <= a;
               lo <= b;
            end
         end else if (state == CALC) begin
            cnt_p1 <= cnt_p1 - CNT_W'(1);
         end
         // A flush arriving in FIX cancels the commit.
         if (state == FIX && !flush) {hi, lo} <= hilo_fix;
      end
   end

endmodule

// File: tb/tb_mdu_acc.sv
// Scoreboard bench for mdu_acc: driver queues expected HI/LO/dbz/latency, monitor checks on out_valid.
module tb_mdu_acc;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         flush = 1'b0;
   logic         out_ready = 1'b1;
   logic [2:0]   op = 3'b000;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, dbz;
   logic [W-1:0] hi, lo;

   always #5 clk = ~clk;

   mdu_acc #(.WIDTH(W), .BITS_PER_CYC(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .hi(hi), .lo(lo), .dbz(dbz)
   );

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   logic ov_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         ov_prev = 1'b0;
      end else begin
         if (out_valid && !ov_prev) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out_valid: got 1 expected 0");
            end else begin
               chk({sbq[0].name, "_latency"}, 64'(cyc - sbq[0].acc_cyc), 64'(sbq[0].lat));
               chk({sbq[0].name, "_in_ready"}, 64'(in_ready), 64'd0);
            end
         end
         if (out_valid && out_ready && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
            chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
            chk({e.name, "_dbz"}, 64'(dbz), 64'(e.dbz));
         end
         ov_prev = out_valid;
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL wait_in_ready: got 0 expected 1 within 200 cycles");
      end
   endtask

   task automatic drive(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib);
      wait_ready();
      op = o;
      a = ia;
      b = ib;
      in_valid = 1'b1;
   endtask

   task automatic issue(input string name, input logic [2:0] o, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [31:0] eh, input logic [31:0] el,
                        input logic ed, input int lat);
      exp_t e;
      drive(o, ia, ib);
      e.name = name;
      e.hi = eh;
      e.lo = el;
      e.dbz = ed;
      e.lat = lat;
      e.acc_cyc = cyc;
      sbq.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() > 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (sbq.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_dbz", 64'(dbz), 64'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      issue("mult_neg",  3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34);
      issue("mthilo",    3'b111, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 1'b0, 1);
      issue("maddu",     3'b011, 32'd1, 32'd1, 32'h1, 32'h0, 1'b0, 34);
      issue("msub",      3'b100, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 1'b0, 34);
`ifdef MDU_DIV_EN
      issue("div_neg",   3'b101, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
      issue("divu",      3'b110, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC, 1'b0, 34);
      issue("div_zero",  3'b101, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1, 2);
      issue("div_min",   3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34);
`else
      issue("div_neg",   3'b101, 32'hFFFFFFF9, 32'd2, 32'h0, 32'hFFFFFFFF, 1'b1, 1);
      issue("divu",      3'b110, 32'hFFFFFFF9, 32'd2, 32'h0, 32'hFFFFFFFF, 1'b1, 1);
      issue("div_zero",  3'b101, 32'h1234, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1, 1);
      issue("div_min",   3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 1'b1, 1);
`endif
      issue("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
      issue("madd_neg",  3'b010, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFD, 32'hFFFFFFFB, 1'b0, 34);
      drain();

      // Backpressure: result held for 5 cycles, accepted on the 6th.
      out_ready = 1'b0;
      issue("bp", 3'b111, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_hi", 64'(hi), 64'hA5A5A5A5);
         chk("bp_lo", 64'(lo), 64'h5A5A5A5A);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_in_ready", 64'(in_ready), 64'd1);
      chk("bp_release_out_valid", 64'(out_valid), 64'd0);
      drain();

      // Flush in CALC cycle 10.
      drive(3'b000, 32'd7, 32'd7);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_hi", 64'(hi), 64'hA5A5A5A5);
      chk("flush_lo", 64'(lo), 64'h5A5A5A5A);
      repeat (40) @(posedge clk);
      #1;
      chk("flush_hi_later", 64'(hi), 64'hA5A5A5A5);
      chk("flush_lo_later", 64'(lo), 64'h5A5A5A5A);

      // Flush in IDLE drops the simultaneous request.
      drive(3'b111, 32'h1, 32'h2);
      flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      flush = 1'b0;
      chk("idle_flush_in_ready", 64'(in_ready), 64'd1);
      chk("idle_flush_out_valid", 64'(out_valid), 64'd0);
      chk("idle_flush_hi", 64'(hi), 64'hA5A5A5A5);
      chk("idle_flush_lo", 64'(lo), 64'h5A5A5A5A);

      // Asynchronous reset mid-CALC.
      drive(3'b000, 32'd3, 32'd3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_hi", 64'(hi), 64'd0);
      chk("arst_lo", 64'(lo), 64'd0);
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      issue("post_rst_mult", 3'b000, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 34);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
